// File: rtl/mult_ctrl_pkg.sv
// Shared definitions for the multiplier scheduler: FSM state encoding,
// default parameter values and the clog2 helper used to size ID/counter fields.
package mult_ctrl_pkg;

    // Controller states: wait for a request, run the multiplier, present the response
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 32;
    localparam int DEF_TIMEOUT = 64;

    // Ceiling log2, minimum 1 so that a field derived from it is never zero-width
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        for (int i = 0; i < 32; i++) begin
            if (rem > 0) begin
                result = result + 1;
                rem    = rem >> 1;
            end else begin
                rem = rem;
            end
        end
        if (result < 1) begin
            result = 1;
        end else begin
            result = result;
        end
        return result;
    endfunction

endpackage

// File: rtl/mult_sched_rr_arbiter.sv
// Round-robin arbiter: searches upward from the slot after the pointer and
// grants the first requesting slot. Purely combinational; the caller owns the pointer.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    idx_o
);

    logic            found_s;
    logic [ID_W-1:0] cand_s;

    // Walk the requesters in rotating priority order, last winner gets lowest priority
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        found_s = 1'b0;
        cand_s  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_s = ID_W'((int'(ptr_i) + k) % NUM_REQ);
            if (en_i && !found_s && req_i[cand_s]) begin
                found_s        = 1'b1;
                gnt_o[cand_s]  = 1'b1;
                idx_o          = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/mult_sched.sv
// Multiplier scheduler: shares one multi-cycle multiplier between NUM_REQ
// clients. Round-robin grant in IDLE, operands held for the whole operation,
// done/timeout handling in BUSY, one tagged response channel in RESP.
module mult_sched
    import mult_ctrl_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [clog2(NUM_REQ)-1:0]  rsp_id,
    output logic [2*WIDTH-1:0]         rsp_result,
    output logic                       rsp_timeout,
    output logic [WIDTH-1:0]           mul_multiplicand,
    output logic [WIDTH-1:0]           mul_multiplier,
    output logic                       mul_enable,
    input  logic                       mul_done,
    input  logic [2*WIDTH-1:0]         mul_result
);

    localparam int ID_W  = clog2(NUM_REQ);
    localparam int CNT_W = clog2(TIMEOUT);

    state_e               state_q;
    logic [ID_W-1:0]      ptr_q;
    logic [ID_W-1:0]      id_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [2*WIDTH-1:0]   result_q;
    logic                 timeout_q;
    logic                 rsp_valid_q;
    logic                 mul_enable_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;

    logic                 arb_en_s;
    logic [NUM_REQ-1:0]   arb_gnt_s;
    logic [ID_W-1:0]      arb_idx_s;
    logic                 accept_s;
    logic                 cnt_expired_s;
    logic [WIDTH-1:0]     sel_a_s;
    logic [WIDTH-1:0]     sel_b_s;

    // Grants are only offered while idle; the arbiter only grants valid requesters
    assign arb_en_s = (state_q == ST_IDLE);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .en_i  (arb_en_s),
        .gnt_o (arb_gnt_s),
        .idx_o (arb_idx_s)
    );

    // A grant is only ever raised for a valid requester, so any grant bit is an accept
    assign req_ready = arb_gnt_s;
    assign accept_s  = |arb_gnt_s;

    // One-hot AND-OR mux picks the granted requester's operands
    always_comb begin
        sel_a_s = '0;
        sel_b_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_a_s = sel_a_s | ({WIDTH{arb_gnt_s[i]}} & req_a[i*WIDTH +: WIDTH]);
            sel_b_s = sel_b_s | ({WIDTH{arb_gnt_s[i]}} & req_b[i*WIDTH +: WIDTH]);
        end
    end

    // Timeout bookkeeping: expire on the TIMEOUT-th enabled cycle without done
    always_comb begin
        cnt_d         = cnt_q + CNT_W'(1);
        cnt_expired_s = (cnt_q == CNT_W'(TIMEOUT - 1));
    end

    // Controller FSM with all outputs registered; async reset aborts any operation silently
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ptr_q        <= ID_W'(NUM_REQ - 1);
            id_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            result_q     <= '0;
            timeout_q    <= 1'b0;
            rsp_valid_q  <= 1'b0;
            mul_enable_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        a_q          <= sel_a_s;
                        b_q          <= sel_b_s;
                        id_q         <= arb_idx_s;
                        ptr_q        <= arb_idx_s;
                        cnt_q        <= '0;
                        mul_enable_q <= 1'b1;
                        state_q      <= ST_BUSY;
                    end else begin
                        mul_enable_q <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    // done takes priority over a coincident timeout
                    if (mul_done) begin
                        result_q     <= mul_result;
                        timeout_q    <= 1'b0;
                        rsp_valid_q  <= 1'b1;
                        mul_enable_q <= 1'b0;
                        state_q      <= ST_RESP;
                    end else if (cnt_expired_s) begin
                        result_q     <= '0;
                        timeout_q    <= 1'b1;
                        rsp_valid_q  <= 1'b1;
                        mul_enable_q <= 1'b0;
                        state_q      <= ST_RESP;
                    end else begin
                        cnt_q        <= cnt_d;
                        mul_enable_q <= 1'b1;
                    end
                end
                ST_RESP: begin
                    // response fields stay frozen until the consumer takes them
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else begin
                        rsp_valid_q <= 1'b1;
                    end
                end
                default: begin
                    rsp_valid_q  <= 1'b0;
                    mul_enable_q <= 1'b0;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid        = rsp_valid_q;
    assign rsp_id           = id_q;
    assign rsp_result       = result_q;
    assign rsp_timeout      = timeout_q;
    assign mul_multiplicand = a_q;
    assign mul_multiplier   = b_q;
    assign mul_enable       = mul_enable_q;

endmodule

// File: tb/tb_mult_sched.sv
// Directed testbench for mult_sched: the bench plays the multiplier and the
// response consumer and checks every expected value against hand-computed constants.
module tb_mult_sched;

    logic          clk;
    logic          rst_n;
    logic [3:0]    req_valid;
    logic [3:0]    req_ready;
    logic [127:0]  req_a;
    logic [127:0]  req_b;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_id;
    logic [63:0]   rsp_result;
    logic          rsp_timeout;
    logic [31:0]   mul_multiplicand;
    logic [31:0]   mul_multiplier;
    logic          mul_enable;
    logic          mul_done;
    logic [63:0]   mul_result;

    int checks = 0;
    int errors = 0;

    mult_sched #(
        .NUM_REQ (4),
        .WIDTH   (32),
        .TIMEOUT (64)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_a            (req_a),
        .req_b            (req_b),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_id           (rsp_id),
        .rsp_result       (rsp_result),
        .rsp_timeout      (rsp_timeout),
        .mul_multiplicand (mul_multiplicand),
        .mul_multiplier   (mul_multiplier),
        .mul_enable       (mul_enable),
        .mul_done         (mul_done),
        .mul_result       (mul_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b);
        req_a[idx*32 +: 32] = a;
        req_b[idx*32 +: 32] = b;
    endtask

    // One complete operation with immediate done and a consumer that is always ready
    task automatic serve(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] prod);
        logic [3:0] exp_gnt;
        exp_gnt = 4'b0001 << id;
        #1;
        check("grant", {60'd0, req_ready}, {60'd0, exp_gnt});
        tick();
        check("busy_enable", {63'd0, mul_enable}, 64'd1);
        check("busy_ready", {60'd0, req_ready}, 64'd0);
        check("busy_opa", {32'd0, mul_multiplicand}, {32'd0, a});
        check("busy_opb", {32'd0, mul_multiplier}, {32'd0, b});
        mul_done   = 1'b1;
        mul_result = prod;
        tick();
        mul_done   = 1'b0;
        mul_result = 64'd0;
        check("rsp_valid", {63'd0, rsp_valid}, 64'd1);
        check("rsp_id", {62'd0, rsp_id}, id);
        check("rsp_result", rsp_result, prod);
        check("rsp_timeout", {63'd0, rsp_timeout}, 64'd0);
        check("resp_enable", {63'd0, mul_enable}, 64'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_released", {63'd0, rsp_valid}, 64'd0);
    endtask

    initial begin
        int n;
        rst_n      = 1'b1;
        req_valid  = 4'b0000;
        req_a      = 128'd0;
        req_b      = 128'd0;
        rsp_ready  = 1'b0;
        mul_done   = 1'b0;
        mul_result = 64'd0;
        #1;
        rst_n = 1'b0;
        #1;

        // Reset state
        check("rst_ready", {60'd0, req_ready}, 64'd0);
        check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_rsp_id", {62'd0, rsp_id}, 64'd0);
        check("rst_rsp_result", rsp_result, 64'd0);
        check("rst_rsp_timeout", {63'd0, rsp_timeout}, 64'd0);
        check("rst_enable", {63'd0, mul_enable}, 64'd0);
        check("rst_opa", {32'd0, mul_multiplicand}, 64'd0);
        check("rst_opb", {32'd0, mul_multiplier}, 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Fairness: all four valid, grants 0,1,2,3,0
        set_req(0, 32'd3, 32'd5);
        set_req(1, 32'd4, 32'd9);
        set_req(2, 32'd100, 32'd100);
        set_req(3, 32'h0001_0000, 32'h0001_0000);
        req_valid = 4'b1111;
        serve(0, 32'd3, 32'd5, 64'd15);
        serve(1, 32'd4, 32'd9, 64'd36);
        serve(2, 32'd100, 32'd100, 64'd10000);
        serve(3, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);
        serve(0, 32'd3, 32'd5, 64'd15);
        req_valid = 4'b0000;

        // Single request from requester 2, done on the third enabled cycle
        set_req(2, 32'd7, 32'd6);
        req_valid = 4'b0100;
        #1;
        check("t1_grant", {60'd0, req_ready}, 64'h4);
        tick();
        req_valid = 4'b0000;
        check("t1_enable", {63'd0, mul_enable}, 64'd1);
        check("t1_opa", {32'd0, mul_multiplicand}, 64'd7);
        check("t1_opb", {32'd0, mul_multiplier}, 64'd6);
        tick();
        check("t1_no_rsp_yet", {63'd0, rsp_valid}, 64'd0);
        tick();
        mul_done   = 1'b1;
        mul_result = 64'd42;
        tick();
        mul_done   = 1'b0;
        mul_result = 64'd0;
        check("t1_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        check("t1_rsp_id", {62'd0, rsp_id}, 64'd2);
        check("t1_rsp_result", rsp_result, 64'd42);
        check("t1_rsp_timeout", {63'd0, rsp_timeout}, 64'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("t1_released", {63'd0, rsp_valid}, 64'd0);

        // Backpressure: response held for 5 cycles, no new grant meanwhile
        set_req(0, 32'd12, 32'd13);
        set_req(1, 32'd1000, 32'd1000);
        req_valid = 4'b0011;
        #1;
        check("t3_grant", {60'd0, req_ready}, 64'h1);
        tick();
        mul_done   = 1'b1;
        mul_result = 64'd156;
        tick();
        mul_done   = 1'b0;
        mul_result = 64'd0;
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_valid", {63'd0, rsp_valid}, 64'd1);
            check("t3_hold_id", {62'd0, rsp_id}, 64'd0);
            check("t3_hold_result", rsp_result, 64'd156);
            check("t3_hold_enable", {63'd0, mul_enable}, 64'd0);
            check("t3_hold_ready", {60'd0, req_ready}, 64'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("t3_released", {63'd0, rsp_valid}, 64'd0);
        serve(1, 32'd1000, 32'd1000, 64'd1000000);
        req_valid = 4'b0000;

        // Full-scale operands pass through unwidened, operands stable while enabled
        set_req(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        req_valid = 4'b1000;
        #1;
        check("t5_grant", {60'd0, req_ready}, 64'h8);
        tick();
        req_valid = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            check("t5_enable", {63'd0, mul_enable}, 64'd1);
            check("t5_opa", {32'd0, mul_multiplicand}, 64'h0000_0000_FFFF_FFFF);
            check("t5_opb", {32'd0, mul_multiplier}, 64'h0000_0000_FFFF_FFFF);
            tick();
        end
        mul_done   = 1'b1;
        mul_result = 64'hFFFF_FFFE_0000_0001;
        tick();
        mul_done   = 1'b0;
        mul_result = 64'd0;
        check("t5_rsp_id", {62'd0, rsp_id}, 64'd3);
        check("t5_rsp_result", rsp_result, 64'hFFFF_FFFE_0000_0001);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Timeout: no done, enable high exactly 64 cycles
        set_req(2, 32'd5, 32'd5);
        req_valid = 4'b0100;
        #1;
        check("t4_grant", {60'd0, req_ready}, 64'h4);
        tick();
        req_valid = 4'b0000;
        n = 0;
        while (mul_enable === 1'b1 && n < 200) begin
            n++;
            tick();
        end
        check("t4_enable_cycles", n, 64'd64);
        check("t4_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        check("t4_rsp_timeout", {63'd0, rsp_timeout}, 64'd1);
        check("t4_rsp_result", rsp_result, 64'd0);
        check("t4_rsp_id", {62'd0, rsp_id}, 64'd2);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Done arriving on the last allowed cycle beats the timeout
        req_valid = 4'b0001;
        #1;
        check("tw_grant", {60'd0, req_ready}, 64'h1);
        tick();
        req_valid = 4'b0000;
        for (int i = 0; i < 63; i++) begin
            tick();
        end
        check("tw_enable_last", {63'd0, mul_enable}, 64'd1);
        mul_done   = 1'b1;
        mul_result = 64'd156;
        tick();
        mul_done   = 1'b0;
        mul_result = 64'd0;
        check("tw_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        check("tw_rsp_timeout", {63'd0, rsp_timeout}, 64'd0);
        check("tw_rsp_result", rsp_result, 64'd156);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Reset during BUSY aborts silently
        req_valid = 4'b0010;
        #1;
        check("t6_grant", {60'd0, req_ready}, 64'h2);
        tick();
        check("t6_enable", {63'd0, mul_enable}, 64'd1);
        #2;
        req_valid = 4'b0000;
        rst_n     = 1'b0;
        #1;
        check("t6_rst_enable", {63'd0, mul_enable}, 64'd0);
        check("t6_rst_valid", {63'd0, rsp_valid}, 64'd0);
        check("t6_rst_ready", {60'd0, req_ready}, 64'd0);
        check("t6_rst_opa", {32'd0, mul_multiplicand}, 64'd0);
        check("t6_rst_result", rsp_result, 64'd0);
        check("t6_rst_id", {62'd0, rsp_id}, 64'd0);
        tick();
        tick();
        rst_n      = 1'b1;
        mul_done   = 1'b1;
        mul_result = 64'd123;
        tick();
        tick();
        check("t6_stray_done_valid", {63'd0, rsp_valid}, 64'd0);
        check("t6_stray_done_enable", {63'd0, mul_enable}, 64'd0);
        mul_done   = 1'b0;
        mul_result = 64'd0;
        req_valid  = 4'b1111;
        serve(0, 32'd12, 32'd13, 64'd156);
        req_valid = 4'b0000;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
